// File: rtl/jt6295_slot_sched_pkg.sv
// Shared types and constants for the JT6295 slot scheduler.
package jt6295_slot_sched_pkg;

  // Voice slots per sample period
  localparam int SLOTS = 4;
  // Tick counter width; wide enough for either divider value
  localparam int TW = 8;

  // Fetch FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } fetch_st_t;

endpackage

// File: rtl/jt6295_slot_sched_if.sv
// Voice/ROM bus of the slot scheduler.
//
// Handshake: rom_cs is a request held high with rom_addr stable until the
// ROM answers with a one-clk rom_ok (rom_data valid on that clk) or the
// slot ends. An rom_ok on the first clk of a request is stale and ignored.
// Voice side: ch_vld or ch_miss is a one-clk pulse for voice ch_idx; the two
// are never high together, and ch_data holds until the next ch_vld.
interface jt6295_slot_sched_if #(
  parameter int AW = 18,
  parameter int DW = 8
);
  logic [3:0]      ch_req;
  logic [4*AW-1:0] ch_addr;
  logic [AW-1:0]   rom_addr;
  logic            rom_cs;
  logic [DW-1:0]   rom_data;
  logic            rom_ok;
  logic [DW-1:0]   ch_data;
  logic            ch_vld;
  logic [1:0]      ch_idx;
  logic            ch_miss;

  // Scheduler side
  modport master (
    input  ch_req, ch_addr, rom_data, rom_ok,
    output rom_addr, rom_cs, ch_data, ch_vld, ch_idx, ch_miss
  );

  // Voices plus ROM bridge side
  modport slave (
    output ch_req, ch_addr, rom_data, rom_ok,
    input  rom_addr, rom_cs, ch_data, ch_vld, ch_idx, ch_miss
  );
endinterface

// File: rtl/jt6295_slot_timer.sv
// Sample/slot timing: counts cen ticks per sample, splits the sample into
// four slots (slot 3 takes the remainder) and produces the cen4/cen pair.
module jt6295_slot_timer
  import jt6295_slot_sched_pkg::*;
#(
  parameter int DIV_HI = 165,
  parameter int DIV_LO = 132
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       ss,
  output logic       slot_cen,
  output logic       smp_cen,
  output logic [1:0] slot,
  output logic [1:0] nslot
);

  logic [TW-1:0] tick;
  logic [TW-1:0] div;
  logic [TW-1:0] len;
  logic [TW-1:0] len2;
  logic [TW-1:0] len3;
  logic          is_start;

  assign len  = {2'b00, div[TW-1:2]};
  assign len2 = len + len;
  assign len3 = len2 + len;

  // Slot owning the current tick and whether the tick opens a slot
  always_comb begin
    nslot = 2'd3;
    if (tick < len)
      nslot = 2'd0;
    else if (tick < len2)
      nslot = 2'd1;
    else if (tick < len3)
      nslot = 2'd2;
    is_start = (tick == '0) || (tick == len) || (tick == len2) || (tick == len3);
  end

  // Strobes ride on cen; masked during reset so outputs stay low
  assign slot_cen = cen & is_start & ~rst;
  assign smp_cen  = cen & (tick == '0) & ~rst;

  // Tick counter, divider latched only at the sample wrap, slot index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick <= '0;
      div  <= TW'(DIV_HI);
      slot <= 2'd0;
    end else if (cen) begin
      if (tick == div - TW'(1)) begin
        tick <= '0;
        div  <= ss ? TW'(DIV_LO) : TW'(DIV_HI);
      end else begin
        tick <= tick + TW'(1);
      end
      if (is_start)
        slot <= nslot;
    end
  end

endmodule

// File: rtl/jt6295_slot_sched.sv
// JT6295 voice slot scheduler: slot timer plus one ROM fetch per slot on
// behalf of the voice owning the slot.
module jt6295_slot_sched
  import jt6295_slot_sched_pkg::*;
#(
  parameter int AW     = 18,
  parameter int DW     = 8,
  parameter int DIV_HI = 165,
  parameter int DIV_LO = 132
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen,
  input  logic                 ss,
  jt6295_slot_sched_if.master  bus,
  output logic                 smp_cen,
  output logic                 slot_cen,
  output logic [1:0]           slot,
  output fetch_st_t            st
);

  logic [1:0]    nslot;
  logic [1:0]    sel;
  logic [AW-1:0] sel_addr;
  logic          first;
  logic          pend;
  logic [1:0]    fslot;
  logic [AW-1:0] rom_addr_r;
  logic          rom_cs_r;
  logic [DW-1:0] ch_data_r;
  logic          ch_vld_r;
  logic [1:0]    ch_idx_r;
  logic          ch_miss_r;

  jt6295_slot_timer #(
    .DIV_HI (DIV_HI),
    .DIV_LO (DIV_LO)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .ss       (ss),
    .slot_cen (slot_cen),
    .smp_cen  (smp_cen),
    .slot     (slot),
    .nslot    (nslot)
  );

  // A fresh slot uses the incoming index; a slot re-evaluated after a miss
  // uses the already-updated slot register
  assign sel = slot_cen ? nslot : slot;

  // Address mux for the voice under evaluation
  always_comb begin
    sel_addr = bus.ch_addr[0 +: AW];
    case (sel)
      2'd1:    sel_addr = bus.ch_addr[AW   +: AW];
      2'd2:    sel_addr = bus.ch_addr[2*AW +: AW];
      2'd3:    sel_addr = bus.ch_addr[3*AW +: AW];
      default: sel_addr = bus.ch_addr[0 +: AW];
    endcase
  end

  // Fetch FSM: issue, await rom_ok (skipping the stale first clk), or miss
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= ST_IDLE;
      first      <= 1'b0;
      pend       <= 1'b0;
      fslot      <= 2'd0;
      rom_addr_r <= '0;
      rom_cs_r   <= 1'b0;
      ch_data_r  <= '0;
      ch_vld_r   <= 1'b0;
      ch_idx_r   <= 2'd0;
      ch_miss_r  <= 1'b0;
    end else begin
      ch_vld_r  <= 1'b0;
      ch_miss_r <= 1'b0;
      case (st)
        ST_IDLE, ST_DONE: begin
          if (slot_cen || pend) begin
            pend <= 1'b0;
            if (bus.ch_req[sel]) begin
              rom_cs_r   <= 1'b1;
              rom_addr_r <= sel_addr;
              fslot      <= sel;
              first      <= 1'b1;
              st         <= ST_REQ;
            end else begin
              st <= ST_IDLE;
            end
          end
        end
        ST_REQ: begin
          first <= 1'b0;
          if (!first && bus.rom_ok) begin
            ch_data_r <= bus.rom_data;
            ch_vld_r  <= 1'b1;
            ch_idx_r  <= fslot;
            rom_cs_r  <= 1'b0;
            st        <= ST_DONE;
          end else if (slot_cen) begin
            // Drop cs for one clk; the new slot is looked at next clk
            ch_miss_r <= 1'b1;
            ch_idx_r  <= fslot;
            rom_cs_r  <= 1'b0;
            pend      <= 1'b1;
            st        <= ST_IDLE;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign bus.rom_addr = rom_addr_r;
  assign bus.rom_cs   = rom_cs_r;
  assign bus.ch_data  = ch_data_r;
  assign bus.ch_vld   = ch_vld_r;
  assign bus.ch_idx   = ch_idx_r;
  assign bus.ch_miss  = ch_miss_r;

endmodule

// File: tb/tb_jt6295_slot_sched.sv
// Bench for jt6295_slot_sched: slot timing table plus fetch sequences.
module tb_jt6295_slot_sched;
  import jt6295_slot_sched_pkg::*;

  localparam int AW = 18;
  localparam int DW = 8;
  localparam int EW = 19;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic       ss  = 1'b0;
  logic       smp_cen;
  logic       slot_cen;
  logic [1:0] slot;
  fetch_st_t  st;

  always #5 clk = ~clk;

  jt6295_slot_sched_if #(.AW(AW), .DW(DW)) bus();

  jt6295_slot_sched dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .ss       (ss),
    .bus      (bus.master),
    .smp_cen  (smp_cen),
    .slot_cen (slot_cen),
    .slot     (slot),
    .st       (st)
  );

  // cen every 4 clk
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      cen = (ph == 0);
      ph = (ph + 1) % 4;
    end
  end

  // ROM responder: 0 = ok 3 clk after cs, 1 = ok always high, 2 = as 0 but never for 0x200
  int mode = 0;
  initial begin
    int cs_cnt;
    cs_cnt = 0;
    bus.rom_ok = 1'b0;
    bus.rom_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.rom_cs) cs_cnt++;
      else cs_cnt = 0;
      case (mode)
        1:       bus.rom_ok = 1'b1;
        2:       bus.rom_ok = (cs_cnt == 3) && (bus.rom_addr != 18'h200);
        default: bus.rom_ok = (cs_cnt == 3);
      endcase
      bus.rom_data = bus.rom_addr[15:8] ^ 8'h5A;
    end
  end

  // ---------------- monitor ----------------
  typedef struct { int gap; logic smp; logic [1:0] slot; } tev_t;
  typedef struct { logic miss; logic [1:0] idx; logic [7:0] data; int lat; logic both; } fev_t;
  typedef struct { logic [AW-1:0] addr; int lo_gap; } aev_t;

  tev_t ev_q[$];
  fev_t got_q[$];
  aev_t addr_q[$];
  logic [EW-1:0] exp_q[$];

  int   cyc = 0, cen_cnt = 0, last_cnt = 0, cs_rise_cyc = 0, cs_fall_cyc = 0;
  logic pend_slot = 1'b0, prev_cs = 1'b0;
  tev_t cur;

  always @(negedge clk) begin
    cyc++;
    if (pend_slot) begin
      cur.slot = slot;
      ev_q.push_back(cur);
      pend_slot = 1'b0;
    end
    if (cen) cen_cnt++;
    if (rst) begin
      last_cnt = cen_cnt;
      pend_slot = 1'b0;
      prev_cs = 1'b0;
      cs_fall_cyc = cyc;
    end else begin
      if (slot_cen) begin
        cur.gap = cen_cnt - last_cnt;
        cur.smp = smp_cen;
        last_cnt = cen_cnt;
        pend_slot = 1'b1;
      end
      if (bus.rom_cs && !prev_cs) begin
        addr_q.push_back('{addr: bus.rom_addr, lo_gap: cyc - cs_fall_cyc});
        cs_rise_cyc = cyc;
      end
      if (!bus.rom_cs && prev_cs) cs_fall_cyc = cyc;
      if (bus.ch_vld || bus.ch_miss)
        got_q.push_back('{miss: bus.ch_miss, idx: bus.ch_idx, data: bus.ch_data,
                          lat: cyc - cs_rise_cyc, both: bus.ch_vld & bus.ch_miss});
      prev_cs = bus.rom_cs;
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] enc(input logic miss, input logic [1:0] idx,
                                        input logic [7:0] data, input int lat);
    return {miss, idx, data, lat[7:0]};
  endfunction

  task automatic wait_got(input int n, input string name);
    int k;
    k = 0;
    while (got_q.size() < n && k < 5000) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(name, 32'(got_q.size() >= n), 32'd1);
  endtask

  task automatic check_fetches(input string tag);
    int i;
    i = 0;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      fev_t g;
      g = got_q.pop_front();
      chk($sformatf("%s_ev%0d", tag, i), 32'(enc(g.miss, g.idx, g.data, g.lat)), 32'(exp_q.pop_front()));
      chk($sformatf("%s_both%0d", tag, i), 32'(g.both), 32'd0);
      i++;
    end
  endtask

  task automatic check_addr(input string name, input logic [AW-1:0] exp);
    aev_t a;
    if (addr_q.size() == 0) begin
      chk(name, 32'hFFFF_FFFF, 32'(exp));
    end else begin
      a = addr_q.pop_front();
      chk(name, 32'(a.addr), 32'(exp));
    end
  endtask

  task automatic do_reset(input int m, input logic [3:0] req, input logic s);
    @(posedge clk);
    #2;
    rst = 1'b1;
    mode = m;
    bus.ch_req = req;
    ss = s;
    repeat (3) @(posedge clk);
    #2;
    ev_q.delete();
    got_q.delete();
    addr_q.delete();
    exp_q.delete();
    rst = 1'b0;
  endtask

  // ---------------- timing table ----------------
  typedef struct { logic ss; int gap; logic smp; logic [1:0] slot; } tvec_t;
  tvec_t tv[14];

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ch_req  = 4'h0;
    bus.ch_addr = {18'h300, 18'h200, 18'h100, 18'h000};

    tv[0]  = '{1'b0,  1, 1'b1, 2'd0};
    tv[1]  = '{1'b0, 41, 1'b0, 2'd1};
    tv[2]  = '{1'b0, 41, 1'b0, 2'd2};
    tv[3]  = '{1'b0, 41, 1'b0, 2'd3};
    tv[4]  = '{1'b1, 42, 1'b1, 2'd0};
    tv[5]  = '{1'b1, 33, 1'b0, 2'd1};
    tv[6]  = '{1'b1, 33, 1'b0, 2'd2};
    tv[7]  = '{1'b1, 33, 1'b0, 2'd3};
    tv[8]  = '{1'b1, 33, 1'b1, 2'd0};
    tv[9]  = '{1'b1, 33, 1'b0, 2'd1};
    tv[10] = '{1'b0, 33, 1'b0, 2'd2};
    tv[11] = '{1'b0, 33, 1'b0, 2'd3};
    tv[12] = '{1'b0, 33, 1'b1, 2'd0};
    tv[13] = '{1'b0, 41, 1'b0, 2'd1};

    // Reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_cs",       32'(bus.rom_cs),   32'd0);
    chk("rst_addr",     32'(bus.rom_addr), 32'd0);
    chk("rst_vld",      32'(bus.ch_vld),   32'd0);
    chk("rst_miss",     32'(bus.ch_miss),  32'd0);
    chk("rst_data",     32'(bus.ch_data),  32'd0);
    chk("rst_slot",     32'(slot),         32'd0);
    chk("rst_slot_cen", 32'(slot_cen),     32'd0);
    chk("rst_smp_cen",  32'(smp_cen),      32'd0);
    chk("rst_st",       32'(st),           32'(ST_IDLE));

    // Slot timing across a rate change
    do_reset(0, 4'h0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      int k;
      tev_t e;
      ss = tv[i].ss;
      k = 0;
      while (ev_q.size() == 0 && k < 2000) begin
        @(negedge clk);
        #1;
        k++;
      end
      chk($sformatf("t%0d_seen", i), 32'(ev_q.size() != 0), 32'd1);
      if (ev_q.size() != 0) begin
        e = ev_q.pop_front();
        chk($sformatf("t%0d_gap", i),  32'(e.gap),  32'(tv[i].gap));
        chk($sformatf("t%0d_smp", i),  32'(e.smp),  32'(tv[i].smp));
        chk($sformatf("t%0d_slot", i), 32'(e.slot), 32'(tv[i].slot));
      end
    end

    // All voices requesting, ROM answers 3 clk after cs
    do_reset(0, 4'hF, 1'b0);
    exp_q.push_back(enc(1'b0, 2'd0, 8'h5A, 3));
    exp_q.push_back(enc(1'b0, 2'd1, 8'h5B, 3));
    exp_q.push_back(enc(1'b0, 2'd2, 8'h58, 3));
    exp_q.push_back(enc(1'b0, 2'd3, 8'h59, 3));
    wait_got(4, "a_wait");
    check_fetches("a");
    check_addr("a_addr0", 18'h000);
    check_addr("a_addr1", 18'h100);
    check_addr("a_addr2", 18'h200);
    check_addr("a_addr3", 18'h300);

    // rom_ok stuck high: first-clk ok ignored, data taken on 2nd clk of cs
    do_reset(1, 4'hF, 1'b0);
    exp_q.push_back(enc(1'b0, 2'd0, 8'h5A, 2));
    exp_q.push_back(enc(1'b0, 2'd1, 8'h5B, 2));
    wait_got(2, "b_wait");
    check_fetches("b");
    check_addr("b_addr0", 18'h000);
    check_addr("b_addr1", 18'h100);

    // Voice 2 never answered: miss at slot-3 boundary, one-clk cs gap, voice 3 served
    do_reset(2, 4'hF, 1'b0);
    exp_q.push_back(enc(1'b0, 2'd0, 8'h5A, 3));
    exp_q.push_back(enc(1'b0, 2'd1, 8'h5B, 3));
    exp_q.push_back(enc(1'b1, 2'd2, 8'h5B, 164));
    exp_q.push_back(enc(1'b0, 2'd3, 8'h59, 3));
    wait_got(4, "c_wait");
    check_fetches("c");
    check_addr("c_addr0", 18'h000);
    check_addr("c_addr1", 18'h100);
    check_addr("c_addr2", 18'h200);
    if (addr_q.size() != 0) chk("c_cs_gap", 32'(addr_q[0].lo_gap), 32'd1);
    check_addr("c_addr3", 18'h300);

    // Reset while a fetch is outstanding
    do_reset(0, 4'hF, 1'b0);
    begin
      int k;
      k = 0;
      while (!bus.rom_cs && k < 100) begin
        @(negedge clk);
        k++;
      end
      chk("d_cs_seen", 32'(bus.rom_cs), 32'd1);
    end
    #1;
    rst = 1'b1;
    #1;
    chk("d_cs_async", 32'(bus.rom_cs),  32'd0);
    chk("d_vld",      32'(bus.ch_vld),  32'd0);
    chk("d_miss",     32'(bus.ch_miss), 32'd0);
    chk("d_slot",     32'(slot),        32'd0);
    chk("d_st",       32'(st),          32'(ST_IDLE));
    repeat (6) @(posedge clk);
    #2;
    chk("d_no_event", 32'(got_q.size()), 32'd0);
    ev_q.delete();
    addr_q.delete();
    rst = 1'b0;
    exp_q.push_back(enc(1'b0, 2'd0, 8'h5A, 3));
    wait_got(1, "d_wait");
    check_fetches("d");
    check_addr("d_addr0", 18'h000);
    if (ev_q.size() != 0) begin
      chk("d_t_gap",  32'(ev_q[0].gap),  32'd1);
      chk("d_t_slot", 32'(ev_q[0].slot), 32'd0);
      chk("d_t_smp",  32'(ev_q[0].smp),  32'd1);
    end else begin
      chk("d_t_seen", 32'd0, 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
